iop_queue: RTL and testbench
============================

# iop_queue

Scheduling queue between the decode stage and the execute stage. It buffers decoded micro-op bundles (`iop`, `iop_init`, `arg`) that the front end produces. It grants feed slots back to the decoder and presents the oldest bundle to execute through a valid/ack handshake. It also flushes on a program-counter redirect and reports whether any queued bundle will write the status flags.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `IOP_W`, 32: micro-op word width.
- `INIT_W`, 3: micro-op init field width.
- `ARG_W`, 16: argument width.
- `SF_BIT`, 21: bit index of the "writes status flags" marker inside `iop`.

Ports:
- `clk` in 1: the only clock. Everything is rising-edge.
- `a_rst` in 1: asynchronous, active-low reset.
- `id_feed_req` in 1: decoder has a bundle to push.
- `id_iop` in IOP_W: micro-op word being pushed.
- `id_iop_init` in INIT_W: init field being pushed.
- `id_arg` in ARG_W: argument being pushed.
- `ex_feed_slot` out 1: queue accepts a push this cycle.
- `flush` in 1: execute redirected the PC (`ex_pc_w`); discard all queued bundles.
- `ex_valid` out 1: head entry is valid.
- `ex_iop` out IOP_W: head micro-op word.
- `ex_iop_init` out INIT_W: head init field.
- `ex_arg` out ARG_W: head argument.
- `ex_ack` in 1: execute consumes the head this cycle.
- `q_sf_busy` out 1: OR of `iop[SF_BIT]` over all valid entries.
- `q_count` out log2(DEPTH)+1: occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries, each {iop, init, arg}.
- Pointers are `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, with natural wrap. `count` runs 0..DEPTH.
- Push and pop conditions:
  - `push = id_feed_req & ex_feed_slot`: write the entry at `wr_ptr`, then increment `wr_ptr`.
  - `pop = ex_valid & ex_ack`: increment `rd_ptr`.
  - `ex_ack` while `ex_valid`=0 is ignored.
- Count update:
  - push only: `count+1`.
  - pop only: `count-1`.
  - both: `count` unchanged, and both pointers advance.
- `ex_feed_slot = (count != DEPTH) & ~flush`.
  - This depends only on registered state plus `flush`. There is no combinational path from `ex_ack`.
  - When the queue is full, a same-cycle pop does not open a slot; the slot appears on the next cycle.
- Head outputs are driven combinationally from the entry at `rd_ptr`. `ex_valid = (count != 0)`.
- `q_sf_busy` is computed from a per-entry valid mask (one bit per slot):
  - The mask bit is set on push and cleared on pop or flush.
  - `q_sf_busy` is the OR of `mask[i] & entry[i].iop[SF_BIT]`.
  - It is combinational from registered state.
- Flush:
  - Synchronous; takes priority over push and pop in the same cycle.
  - Resets `count`, `wr_ptr`, `rd_ptr` and the mask to 0.
  - A push in the flush cycle is blocked, because `ex_feed_slot`=0.
  - A pop in the flush cycle has no additional effect.
  - Entry data is not cleared.
- Reset values:
  - `count`, pointers, mask and all entry fields are 0.
  - Therefore `ex_valid`=0, `ex_iop`/`ex_iop_init`/`ex_arg`=0, `q_sf_busy`=0, `q_count`=0 and `ex_feed_slot`=1.
- Assertion of `a_rst` mid-operation discards everything immediately.

## Timing
- Latency from push to head is 1 cycle: a bundle pushed on edge N is visible with `ex_valid`=1 after edge N. There is no same-cycle bypass.
- Pop takes effect at the clock edge. The next entry, or `ex_valid`=0, is visible after that edge.
- Sustained throughput is 1 push/cycle and 1 pop/cycle whenever 0 < count < DEPTH.
- When `flush` is asserted in cycle N, `ex_valid`=0 and `ex_feed_slot`=1 after edge N, and `flush` has deasserted.
- `q_sf_busy` updates on the same edge as the corresponding push, pop or flush.

## Structure
- The shared core package holds:
  - the entry record typedef (`iop_entry_t`: `iop`, `init`, `arg`);
  - the `SF_BIT` constant, shared with the decoder and status logic.
- No sub-module. Pointer/count logic and the entry array live in a single module.
- `q_count` width is `$clog2(DEPTH)+1`.

## Test plan
- Reset with `a_rst`=0, then release:
  - `ex_feed_slot`=1, `ex_valid`=0, `q_count`=0, `ex_iop`=0.
- Push `iop`=0x0000_00A9, `init`=3, `arg`=0x1234 with `ex_ack`=0:
  - The next cycle shows `ex_valid`=1 and the same three values.
  - `q_count`=1 and `q_sf_busy`=0.
- Fill to DEPTH=4 with `arg` 1..4, `ex_ack`=0:
  - After the 4th push, `ex_feed_slot`=0.
  - A pop plus `id_feed_req` in the full cycle accepts no push and leaves `q_count`=3.
  - The following cycle has `ex_feed_slot`=1.
- Stream 10 bundles with `id_feed_req`=1 and `ex_ack`=1 continuously:
  - `arg` values 0..9 emerge in order, one per cycle after the first.
  - Pointers wrap and `q_count` holds at 1.
- Push an entry with `iop[21]`=1, then an entry with `iop[21]`=0:
  - `q_sf_busy`=1 until the first entry is popped, then 0.
- With 3 entries queued, assert `flush` together with `id_feed_req` and `ex_ack`:
  - The next cycle has `ex_valid`=0, `q_count`=0, `q_sf_busy`=0.
  - A subsequent push appears as the head.

Source files
------------

// File: rtl/iop_queue_pkg.sv
// Shared core definitions for the decode-to-execute scheduling queue:
// default geometry, the status-flag marker bit and the entry record.
package iop_queue_pkg;

    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned IOP_W_DEF  = 32;
    localparam int unsigned INIT_W_DEF = 3;
    localparam int unsigned ARG_W_DEF  = 16;

    // Bit of a micro-op word marking that it writes the status flags
    localparam int unsigned SF_BIT = 21;

    typedef struct packed {
        logic [IOP_W_DEF-1:0]  iop;
        logic [INIT_W_DEF-1:0] init;
        logic [ARG_W_DEF-1:0]  arg;
    } iop_entry_t;

endpackage

// File: rtl/iop_queue_if.sv
// Decoder push port, execute head port and status of the iop queue.
// master = decoder/execute side, slave = the queue itself.
interface iop_queue_if #(
    parameter int unsigned DEPTH  = iop_queue_pkg::DEPTH_DEF,
    parameter int unsigned IOP_W  = iop_queue_pkg::IOP_W_DEF,
    parameter int unsigned INIT_W = iop_queue_pkg::INIT_W_DEF,
    parameter int unsigned ARG_W  = iop_queue_pkg::ARG_W_DEF
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              id_feed_req;
    logic [IOP_W-1:0]  id_iop;
    logic [INIT_W-1:0] id_iop_init;
    logic [ARG_W-1:0]  id_arg;
    logic              ex_feed_slot;
    logic              flush;
    logic              ex_valid;
    logic [IOP_W-1:0]  ex_iop;
    logic [INIT_W-1:0] ex_iop_init;
    logic [ARG_W-1:0]  ex_arg;
    logic              ex_ack;
    logic              q_sf_busy;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output id_feed_req, id_iop, id_iop_init, id_arg, flush, ex_ack,
        input  ex_feed_slot, ex_valid, ex_iop, ex_iop_init, ex_arg,
               q_sf_busy, q_count
    );

    modport slave (
        input  id_feed_req, id_iop, id_iop_init, id_arg, flush, ex_ack,
        output ex_feed_slot, ex_valid, ex_iop, ex_iop_init, ex_arg,
               q_sf_busy, q_count
    );

endinterface

// File: rtl/iop_queue.sv
// Circular-buffer queue of decoded micro-op bundles between decode and
// execute, with PC-redirect flush and a status-flag-writer busy indication.
module iop_queue #(
    parameter int unsigned DEPTH  = iop_queue_pkg::DEPTH_DEF,
    parameter int unsigned IOP_W  = iop_queue_pkg::IOP_W_DEF,
    parameter int unsigned INIT_W = iop_queue_pkg::INIT_W_DEF,
    parameter int unsigned ARG_W  = iop_queue_pkg::ARG_W_DEF,
    parameter int unsigned SF_BIT = iop_queue_pkg::SF_BIT
) (
    input  logic        clk,
    input  logic        a_rst,
    iop_queue_if.slave  q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IOP_W-1:0]  iop;
        logic [INIT_W-1:0] init;
        logic [ARG_W-1:0]  arg;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_mask;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_sf_busy;

    // Slot grant depends only on registered occupancy and flush, never on ex_ack
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == CNT_W'(0));
    assign w_push  = q.id_feed_req & q.ex_feed_slot;
    assign w_pop   = q.ex_valid & q.ex_ack;

    assign q.ex_feed_slot = ~w_full & ~q.flush;
    assign q.ex_valid     = ~w_empty;
    assign q.ex_iop       = r_mem[r_rd_ptr].iop;
    assign q.ex_iop_init  = r_mem[r_rd_ptr].init;
    assign q.ex_arg       = r_mem[r_rd_ptr].arg;
    assign q.q_count      = r_count;
    assign q.q_sf_busy    = w_sf_busy;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (q.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry data survives a flush; only the pointers and mask are cleared
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{iop: q.id_iop, init: q.id_iop_init, arg: q.id_arg};
        end
    end

    // Push and pop never hit the same slot: full blocks push, empty blocks pop
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_mask <= '0;
        end else if (q.flush) begin
            r_mask <= '0;
        end else begin
            if (w_push) r_mask[r_wr_ptr] <= 1'b1;
            if (w_pop)  r_mask[r_rd_ptr] <= 1'b0;
        end
    end

    always_comb begin
        w_sf_busy = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_sf_busy = w_sf_busy | (r_mask[i] & r_mem[i].iop[SF_BIT]);
        end
    end

endmodule

// File: tb/tb_iop_queue.sv
// Randomized and directed bench for iop_queue against a queue-based
// reference model of FIFO order, occupancy and status-flag busy.
module tb_iop_queue;
    import iop_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic a_rst;

    iop_queue_if #(.DEPTH(DEPTH)) bus ();

    iop_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests;
    int         n_fail;
    iop_entry_t model[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_sf();
        logic sf;
        sf = 1'b0;
        foreach (model[i]) sf = sf | model[i].iop[SF_BIT];
        return sf;
    endfunction

    task automatic check_outputs();
        check("ex_valid", 64'(bus.ex_valid), 64'(model.size() != 0));
        check("q_count", 64'(bus.q_count), 64'(model.size()));
        check("q_sf_busy", 64'(bus.q_sf_busy), 64'(model_sf()));
        if (model.size() != 0) begin
            check("ex_iop", 64'(bus.ex_iop), 64'(model[0].iop));
            check("ex_iop_init", 64'(bus.ex_iop_init), 64'(model[0].init));
            check("ex_arg", 64'(bus.ex_arg), 64'(model[0].arg));
        end
    endtask

    // One clock: drive inputs, check the slot grant, advance the model, check after the edge
    task automatic cycle(input logic feed, input logic [31:0] iop, input logic [2:0] init,
                         input logic [15:0] arg, input logic ack, input logic fl);
        iop_entry_t e;
        logic       slot;
        logic       push;
        logic       pop;
        bus.id_feed_req = feed;
        bus.id_iop      = iop;
        bus.id_iop_init = init;
        bus.id_arg      = arg;
        bus.ex_ack      = ack;
        bus.flush       = fl;
        slot = (model.size() != DEPTH) && !fl;
        #1;
        check("ex_feed_slot", 64'(bus.ex_feed_slot), 64'(slot));
        push = feed && slot;
        pop  = (model.size() != 0) && ack;
        if (fl) begin
            model.delete();
        end else begin
            if (pop) void'(model.pop_front());
            if (push) begin
                e.iop  = iop;
                e.init = init;
                e.arg  = arg;
                model.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 3'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) + 1; i++) cycle(1'b0, 32'h0, 3'h0, 16'h0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        bus.id_feed_req = 1'b0;
        bus.ex_ack      = 1'b0;
        bus.flush       = 1'b0;
        a_rst = 1'b0;
        model.delete();
        #1;
        check_outputs();
        check("rst_iop", 64'(bus.ex_iop), 64'h0);
        check("rst_init", 64'(bus.ex_iop_init), 64'h0);
        check("rst_arg", 64'(bus.ex_arg), 64'h0);
        check("rst_slot", 64'(bus.ex_feed_slot), 64'h1);
        @(posedge clk);
        #1;
        a_rst = 1'b1;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        a_rst           = 1'b0;
        bus.id_feed_req = 1'b0;
        bus.id_iop      = '0;
        bus.id_iop_init = '0;
        bus.id_arg      = '0;
        bus.ex_ack      = 1'b0;
        bus.flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        cycle(1'b1, 32'h0000_00A9, 3'd3, 16'h1234, 1'b0, 1'b0);
        check("first_push_arg", 64'(bus.ex_arg), 64'h1234);
        drain();

        // Fill, then pop with a push request while full: push refused
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 3'(i), 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 3'd5, 16'd99, 1'b1, 1'b0);
        check("full_pop_count", 64'(bus.q_count), 64'd3);
        idle();
        drain();

        // Continuous stream with simultaneous push and pop
        cycle(1'b1, 32'h100, 3'd0, 16'd0, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 3'(i), 16'(i), 1'b1, 1'b0);
            check("stream_arg", 64'(bus.ex_arg), 64'(i));
        end
        drain();

        // Status-flag writer followed by a non-writer
        cycle(1'b1, 32'h0020_0001, 3'd1, 16'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0002, 3'd2, 16'hB, 1'b0, 1'b0);
        check("sf_busy_set", 64'(bus.q_sf_busy), 64'h1);
        cycle(1'b0, 32'h0, 3'd0, 16'h0, 1'b1, 1'b0);
        check("sf_busy_clr", 64'(bus.q_sf_busy), 64'h0);
        drain();

        // Flush with push and ack in the same cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0020_0000 | 32'(i), 3'(i), 16'(i + 40), 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 3'd7, 16'd77, 1'b1, 1'b1);
        check("flush_count", 64'(bus.q_count), 64'h0);
        cycle(1'b1, 32'hDEAD_BEEF, 3'd6, 16'hCAFE, 1'b0, 1'b0);
        check("post_flush_head", 64'(bus.ex_arg), 64'hCAFE);
        drain();

        // Randomized traffic with occasional flush and mid-run reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 99) < 70),
                      $urandom() ^ (32'($urandom_range(0, 1)) << SF_BIT),
                      3'($urandom()), 16'($urandom()),
                      ($urandom_range(0, 99) < 55),
                      ($urandom_range(0, 99) < 4));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
